// File: rtl/bcd_xs3_serial_conv.sv
// ---------------------------------------------------------------------------
// bcd_xs3_serial_conv
//
// Sequential BCD <-> Excess-3 converter. A packed word of DIGITS 4-bit digits
// is accepted over a valid/ready handshake and converted one digit per clock,
// least-significant digit first. Each digit is range-checked; an invalid
// digit produces 4'hF in its result slot, and the index of the lowest invalid
// digit is reported on err_pos.
//
// Parameters:
//   DIGITS   number of 4-bit digits per word (1..16)
//   PW       width of err_pos, max(1, $clog2(DIGITS))
//
// Ports:
//   clk        clock, rising-edge active
//   rst        synchronous active-high reset
//   in_valid   input word present
//   in_ready   block can accept a word (IDLE only, low while rst is high)
//   mode       0 = BCD->XS3, 1 = XS3->BCD, sampled together with din
//   din        input digits, digit i at din[4i+3:4i]
//   out_valid  result available (DONE only)
//   out_ready  consumer accepts the result
//   dout       converted digits, same packing as din
//   err        at least one input digit was out of range
//   err_pos    index of the lowest invalid digit, 0 when err is 0
// ---------------------------------------------------------------------------
module bcd_xs3_serial_conv #(
  parameter int DIGITS = 4,
  localparam int PW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   dout,
  output logic                  err,
  output logic [PW-1:0]         err_pos
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [4*DIGITS-1:0] word_q;
  logic                mode_q;
  logic [4*DIGITS-1:0] dout_q;
  logic                err_q;
  logic [PW-1:0]       err_pos_q;
  logic [PW-1:0]       cnt_q;

  logic                accept;
  logic                last_digit;
  logic [3:0]          cur_digit;
  logic                digit_ok;
  logic [3:0]          conv_res;

  // The counter shares err_pos's width: it only ever needs to index
  // DIGITS-1, and the first invalid index is copied straight from it.
  assign last_digit = (cnt_q == PW'(DIGITS - 1));
  assign accept     = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. in_ready is gated by rst so that
  // no word is accepted on the same edge that resets the block.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (accept) begin
          state_d = CONV;
        end
      end
      CONV: begin
        if (last_digit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Select the digit under conversion and compute its result. Wrapping
  // modulo 16 falls out of the 4-bit adder; out-of-range digits are
  // replaced by 4'hF.
  always_comb begin
    cur_digit = '0;
    digit_ok  = 1'b0;
    conv_res  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == PW'(i)) begin
        cur_digit = word_q[4*i +: 4];
      end
    end
    if (!mode_q) begin
      digit_ok = (cur_digit <= 4'd9);
      conv_res = cur_digit + 4'd3;
    end else begin
      digit_ok = (cur_digit >= 4'd3) && (cur_digit <= 4'd12);
      conv_res = cur_digit - 4'd3;
    end
    if (!digit_ok) begin
      conv_res = 4'hF;
    end
  end

  // Datapath: capture on accept, fill one result digit per CONV cycle,
  // hold everything in DONE and IDLE until the next accept clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      mode_q    <= 1'b0;
      dout_q    <= '0;
      err_q     <= 1'b0;
      err_pos_q <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            word_q    <= din;
            mode_q    <= mode;
            dout_q    <= '0;
            err_q     <= 1'b0;
            err_pos_q <= '0;
            cnt_q     <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == PW'(i)) begin
              dout_q[4*i +: 4] <= conv_res;
            end
          end
          // Only the first invalid digit records its position.
          if (!digit_ok && !err_q) begin
            err_q     <= 1'b1;
            err_pos_q <= cnt_q;
          end
          if (!last_digit) begin
            cnt_q <= cnt_q + PW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout    = dout_q;
  assign err     = err_q;
  assign err_pos = err_pos_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_serial_conv
//
// Directed testbench for bcd_xs3_serial_conv. Drives a 4-digit instance and
// a 1-digit instance from a shared clock and reset; expected values are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_serial_conv;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        err;
  logic [1:0]  err_pos;

  logic        in_valid1;
  logic        in_ready1;
  logic        mode1;
  logic [3:0]  din1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  dout1;
  logic        err1;
  logic [0:0]  err_pos1;

  int total;
  int bad;

  bcd_xs3_serial_conv #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err),
    .err_pos   (err_pos)
  );

  bcd_xs3_serial_conv #(.DIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .mode      (mode1),
    .din       (din1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .dout      (dout1),
    .err       (err1),
    .err_pos   (err_pos1)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hand one word to the 4-digit instance and wait for its result. All
  // driving and sampling happens on the falling edge. After the accept the
  // inputs are scrambled to show the word in flight is unaffected.
  task automatic applyStimulus(input logic m, input logic [15:0] d);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    mode     = m;
    din      = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    mode     = ~m;
    din      = ~d;
    checkOutput("in_ready_in_conv", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'd4);
  endtask

  // Compare the held result of the 4-digit instance.
  task automatic expectWord(input string tag, input logic [15:0] exp_dout,
                            input logic exp_err, input logic [1:0] exp_pos);
    checkOutput({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, "_err_pos"}, 32'(err_pos), 32'(exp_pos));
  endtask

  // With out_ready high, DONE lasts one cycle and IDLE follows.
  task automatic expectReturn(input string tag);
    @(negedge clk);
    checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  // One-digit instance: accept, wait, compare.
  task automatic applyStimulus1(input logic m, input logic [3:0] d,
                                input logic [3:0] exp_dout, input logic exp_err);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    mode1     = m;
    din1      = d;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("d1_latency", 32'(lat), 32'd1);
    checkOutput("d1_dout", 32'(dout1), 32'(exp_dout));
    checkOutput("d1_err", 32'(err1), 32'(exp_err));
    checkOutput("d1_err_pos", 32'(err_pos1), 32'd0);
    @(negedge clk);
    checkOutput("d1_out_valid_drop", 32'(out_valid1), 32'd0);
  endtask

  // Main directed sequence.
  initial begin
    logic [15:0] held;
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    mode       = 1'b0;
    din        = '0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    mode1      = 1'b0;
    din1       = '0;
    out_ready1 = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_pos", 32'(err_pos), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic conversions in both directions.
    applyStimulus(1'b0, 16'h1234);
    expectWord("bcd_1234", 16'h4567, 1'b0, 2'd0);
    expectReturn("bcd_1234");

    applyStimulus(1'b1, 16'h4567);
    expectWord("xs3_4567", 16'h1234, 1'b0, 2'd0);
    expectReturn("xs3_4567");

    applyStimulus(1'b1, 16'hC333);
    expectWord("xs3_c333", 16'h9000, 1'b0, 2'd0);
    expectReturn("xs3_c333");

    // Every legal BCD digit maps to digit+3 in all positions.
    for (int dg = 0; dg < 10; dg++) begin
      logic [3:0] dv;
      logic [3:0] ev;
      dv = 4'(dg);
      ev = 4'(dg + 3);
      applyStimulus(1'b0, {4{dv}});
      expectWord($sformatf("sweep_%0d", dg), {4{ev}}, 1'b0, 2'd0);
    end
    @(negedge clk);

    // Invalid digits and lowest-position reporting.
    applyStimulus(1'b0, 16'h9A05);
    expectWord("bcd_9a05", 16'hCF38, 1'b1, 2'd2);
    expectReturn("bcd_9a05");

    applyStimulus(1'b1, 16'h3C2D);
    expectWord("xs3_3c2d", 16'h09FF, 1'b1, 2'd0);
    expectReturn("xs3_3c2d");

    // Backpressure: result held while inputs toggle.
    out_ready = 1'b0;
    applyStimulus(1'b0, 16'h1234);
    expectWord("bp", 16'h4567, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      din      = 16'h9A05 + 16'(i);
      mode     = (i % 2 == 1);
      @(negedge clk);
      checkOutput($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_dout_%0d", i), 32'(dout), 32'h4567);
      checkOutput($sformatf("bp_err_%0d", i), 32'(err), 32'd0);
      checkOutput($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    expectReturn("bp");
    checkOutput("bp_dout_held_idle", 32'(dout), 32'h4567);

    // Reset after two conversion edges discards the partial word.
    mode     = 1'b0;
    din      = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("midrst_dout", 32'(dout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready_back", 32'(in_ready), 32'd1);
    held = dout;
    checkOutput("midrst_dout_after", 32'(held), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("midrst_no_valid_%0d", i), 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b0, 16'h0009);
    expectWord("bcd_0009", 16'h333C, 1'b0, 2'd0);
    expectReturn("bcd_0009");

    // Single-digit instance.
    applyStimulus1(1'b0, 4'h7, 4'hA, 1'b0);
    applyStimulus1(1'b1, 4'h2, 4'hF, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
